// File: rtl/hiscore_uploader.sv
// Hiscore/NVRAM upload engine: answers HPS ioctl upload reads from core RAM
// while the game CPU is paused, then appends a 16-bit additive checksum.
//
// state | meaning
// IDLE  | waiting for an ioctl_rd inside an upload session
// WAITP | request latched, waiting for pause_ack
// FETCH | RAM read issued, counting RAM_LAT cycles
// CHK   | return checksum low/high byte and complete
// FILL  | return 8'hFF for out-of-range index and complete
// DONE  | capture ram_q, update checksum, complete
module hiscore_uploader #(
  parameter int AW      = 10,
  parameter int SIZE    = 1024,
  parameter int RAM_LAT = 2,
  parameter int BASE    = 0
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  output logic          chk_err
);

  typedef enum logic [2:0] {IDLE, WAITP, FETCH, CHK, FILL, DONE} state_t;

  localparam logic [24:0]   SIZE_LO = 25'(SIZE);
  localparam logic [24:0]   SIZE_HI = 25'(SIZE + 1);
  localparam logic [AW-1:0] BASE_A  = AW'(BASE);
  localparam logic [2:0]    LAT_M1  = 3'(RAM_LAT - 1);
  localparam logic [AW:0]   IDX_ONE = (AW+1)'(1);

  state_t      state;
  logic        upload_q;
  logic [24:0] addr_q;
  logic [15:0] sum;
  logic [AW:0] next_idx;
  logic [2:0]  lat_cnt;
  logic        start;
  logic        in_seq;

  assign start  = ioctl_upload & ~upload_q;
  assign in_seq = (addr_q == 25'(next_idx));

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= IDLE;
      upload_q   <= 1'b0;
      addr_q     <= '0;
      sum        <= '0;
      next_idx   <= '0;
      lat_cnt    <= '0;
      ioctl_din  <= 8'hFF;
      ioctl_wait <= 1'b0;
      pause_req  <= 1'b0;
      ram_rd     <= 1'b0;
      ram_addr   <= '0;
      chk_err    <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      ram_rd   <= 1'b0;

      if (!ioctl_upload && state == IDLE)
        pause_req <= 1'b0;

      case (state)
        IDLE: begin
          if (ioctl_rd && ioctl_upload) begin
            addr_q     <= ioctl_addr;
            ioctl_wait <= 1'b1;
            state      <= WAITP;
          end
        end
        WAITP: begin
          if (pause_ack) begin
            if (addr_q < SIZE_LO) begin
              ram_rd   <= 1'b1;
              ram_addr <= BASE_A + addr_q[AW-1:0];
              lat_cnt  <= LAT_M1;
              state    <= FETCH;
            end else if (addr_q == SIZE_LO || addr_q == SIZE_HI) begin
              state <= CHK;
            end else begin
              state <= FILL;
            end
          end
        end
        FETCH: begin
          if (lat_cnt == 3'd0)
            state <= DONE;
          else
            lat_cnt <= lat_cnt - 3'd1;
        end
        CHK: begin
          ioctl_din  <= (addr_q == SIZE_LO) ? sum[7:0] : sum[15:8];
          ioctl_wait <= 1'b0;
          state      <= IDLE;
        end
        FILL: begin
          ioctl_din  <= 8'hFF;
          ioctl_wait <= 1'b0;
          state      <= IDLE;
        end
        DONE: begin
          ioctl_din  <= ram_q;
          ioctl_wait <= 1'b0;
          state      <= IDLE;
          // Only the unbroken in-order prefix of a session is summed.
          if (!in_seq) begin
            chk_err <= 1'b1;
          end else if (!chk_err) begin
            sum      <= sum + {8'h00, ram_q};
            next_idx <= next_idx + IDX_ONE;
          end
        end
        default: state <= IDLE;
      endcase

      if (start) begin
        pause_req <= 1'b1;
        sum       <= '0;
        next_idx  <= '0;
        chk_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hiscore_uploader.sv
// Directed bench for hiscore_uploader: RAM model with fixed latency, delayed
// pause_ack model, vector table for one session plus multi-cycle corner cases.
module tb_hiscore_uploader;
  localparam int AW      = 10;
  localparam int SIZE    = 4;
  localparam int RAM_LAT = 2;
  localparam int BASE    = 1022;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          pause_req;
  logic          pause_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_q;
  logic          chk_err;

  logic          ack_block;
  logic [2:0]    pd = 3'b000;
  logic [7:0]    mem  [0:(1<<AW)-1];
  logic [7:0]    pipe [0:RAM_LAT-1];
  int            rd_pulses = 0;
  int            checks = 0;
  int            failures = 0;

  always #5 clk_sys = ~clk_sys;

  hiscore_uploader #(.AW(AW), .SIZE(SIZE), .RAM_LAT(RAM_LAT), .BASE(BASE)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .pause_req(pause_req), .pause_ack(pause_ack),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q), .chk_err(chk_err)
  );

  // RAM returns data exactly RAM_LAT cycles after ram_rd; junk otherwise.
  always @(posedge clk_sys) begin
    pipe[0] <= ram_rd ? mem[ram_addr] : 8'h5A;
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[RAM_LAT-1];

  always @(posedge clk_sys) pd <= {pd[1:0], pause_req};
  assign pause_ack = pd[2] & ~ack_block;

  always @(posedge clk_sys) if (ram_rd) rd_pulses <= rd_pulses + 1;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  din;
    int          lat;
    int          pulses;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [24:0] a, input logic [7:0] exp_din,
                         input int exp_lat, input int exp_pulses, input string tag);
    int cnt;
    int p0;
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    p0 = rd_pulses;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    cnt = 0;
    while (ioctl_wait && cnt < 200) begin
      cnt++;
      @(negedge clk_sys);
    end
    check({tag, " wait_cycles"}, cnt, exp_lat);
    check({tag, " din"}, ioctl_din, exp_din);
    check({tag, " ram_rd_pulses"}, rd_pulses - p0, exp_pulses);
  endtask

  task automatic start_session(input string tag);
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    repeat (6) @(negedge clk_sys);
    check({tag, " pause_req"}, pause_req, 1);
    check({tag, " chk_err_clear"}, chk_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int p0;
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    ack_block    = 1'b0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[1022] = 8'h11;
    mem[1023] = 8'h22;
    mem[0]    = 8'h33;
    mem[1]    = 8'h44;

    tbl[0] = '{25'd0, 8'h11, 4, 1};
    tbl[1] = '{25'd1, 8'h22, 4, 1};
    tbl[2] = '{25'd2, 8'h33, 4, 1};
    tbl[3] = '{25'd3, 8'h44, 4, 1};
    tbl[4] = '{25'd4, 8'hAA, 2, 0};
    tbl[5] = '{25'd5, 8'h00, 2, 0};
    tbl[6] = '{25'd9, 8'hFF, 2, 0};
    tbl[7] = '{25'd6, 8'hFF, 2, 0};
    tbl[8] = '{25'd4, 8'hAA, 2, 0};

    // Reset held with read strobes toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      ioctl_rd = ~ioctl_rd;
      check("rst wait", ioctl_wait, 0);
      check("rst din", ioctl_din, 8'hFF);
      check("rst pause_req", pause_req, 0);
    end
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    reset_n  = 1'b1;

    do_read(25'd0, 8'hFF, 0, 0, "no_session");
    check("no_session pause_req", pause_req, 0);

    // Session A: in-order reads, checksum, fill.
    start_session("sesA");
    for (int i = 0; i < 9; i++) begin
      do_read(tbl[i].addr, tbl[i].din, tbl[i].lat, tbl[i].pulses, $sformatf("vec%0d", i));
      check($sformatf("vec%0d chk_err", i), chk_err, 0);
    end
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("sesA end pause_req", pause_req, 0);

    // Session B: out-of-order reads.
    start_session("sesB");
    do_read(25'd0, 8'h11, 4, 1, "ooo0");
    do_read(25'd2, 8'h33, 4, 1, "ooo2");
    check("ooo2 chk_err", chk_err, 1);
    do_read(25'd1, 8'h22, 4, 1, "ooo1");
    check("ooo1 chk_err", chk_err, 1);
    do_read(25'd4, 8'h11, 2, 0, "ooo sum_lo");
    do_read(25'd5, 8'h00, 2, 0, "ooo sum_hi");

    // pause_ack held low for 20 cycles.
    @(negedge clk_sys);
    ack_block  = 1'b1;
    ioctl_addr = 25'd3;
    ioctl_rd   = 1'b1;
    p0 = rd_pulses;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("hold wait c%0d", i), ioctl_wait, 1);
      @(negedge clk_sys);
    end
    check("hold no ram_rd", rd_pulses - p0, 0);
    ack_block = 1'b0;
    cnt = 0;
    while (ioctl_wait && cnt < 200) begin
      cnt++;
      @(negedge clk_sys);
    end
    check("hold release wait_cycles", cnt, 4);
    check("hold release din", ioctl_din, 8'h44);
    check("hold release ram_rd_pulses", rd_pulses - p0, 1);

    // Reset asserted mid-FETCH.
    @(negedge clk_sys);
    ioctl_addr = 25'd2;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    check("midrst fetch ram_rd", ram_rd, 1);
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("midrst wait", ioctl_wait, 0);
    check("midrst din", ioctl_din, 8'hFF);
    check("midrst pause_req", pause_req, 0);
    check("midrst ram_rd", ram_rd, 0);
    check("midrst ram_addr", ram_addr, 0);
    check("midrst chk_err", chk_err, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;

    // Session C: upload drops mid-FETCH, pause_ack drops too.
    start_session("sesC");
    @(negedge clk_sys);
    ioctl_addr = 25'd3;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    ack_block    = 1'b1;
    cnt = 0;
    while (ioctl_wait && cnt < 200) begin
      cnt++;
      @(negedge clk_sys);
    end
    check("drop wait_cycles", cnt, 3);
    check("drop din", ioctl_din, 8'h44);
    check("drop pause_req still", pause_req, 1);
    @(negedge clk_sys);
    check("drop pause_req fall", pause_req, 0);
    check("drop chk_err sticky", chk_err, 1);
    ack_block = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
